// File: rtl/otter_regfile_mp.sv
// Multi-port register file for the pipelined OTTER core: async read ports, two write ports
// (WB pipe + long-latency unit) and a per-register busy scoreboard for hazard stalls.
module otter_regfile_mp #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned NREG     = 32,
    parameter int unsigned NREAD    = 2,
    parameter int unsigned BYPASS   = 1,
    parameter int unsigned ZERO_REG = 1,
    localparam int unsigned AW      = $clog2(NREG)
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NREAD*AW-1:0]   i_rd_adr,
    output logic [NREAD*XLEN-1:0] o_rd_data,
    output logic [NREAD-1:0]      o_rd_busy,
    input  logic [1:0]            i_wr_en,
    input  logic [2*AW-1:0]       i_wr_adr,
    input  logic [2*XLEN-1:0]     i_wr_data,
    input  logic                  i_sb_set,
    input  logic [AW-1:0]         i_sb_adr,
    output logic                  o_any_busy
);

    logic [XLEN-1:0] r_regs [NREG];
    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busy_d;
    logic [NREG-1:0] w_we0, w_we1, w_set;

    logic [AW-1:0]   w_wa0, w_wa1;
    logic [XLEN-1:0] w_wd0, w_wd1;

    assign w_wa0 = i_wr_adr[AW-1:0];
    assign w_wa1 = i_wr_adr[2*AW-1:AW];
    assign w_wd0 = i_wr_data[XLEN-1:0];
    assign w_wd1 = i_wr_data[2*XLEN-1:XLEN];

    // Per-register decode; addresses >= NREG match no register and are dropped.
    always_comb begin
        w_we0 = '0;
        w_we1 = '0;
        w_set = '0;
        for (int unsigned r = 0; r < NREG; r++) begin
            if (!(ZERO_REG != 0 && r == 0)) begin
                w_we0[r] = i_wr_en[0] && (w_wa0 == AW'(r));
                w_we1[r] = i_wr_en[1] && (w_wa1 == AW'(r));
                w_set[r] = i_sb_set && (i_sb_adr == AW'(r));
            end
        end
        // A new issue to a register outranks the retiring write to it.
        w_busy_d = w_set | (r_busy & ~(w_we0 | w_we1));
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                r_regs[r] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                if (w_we1[r]) begin
                    r_regs[r] <= w_wd1;
                end else if (w_we0[r]) begin
                    r_regs[r] <= w_wd0;
                end
            end
            r_busy <= w_busy_d;
        end
    end

    for (genvar g = 0; g < int'(NREAD); g++) begin : g_rd
        logic [AW-1:0]   w_adr;
        logic            w_valid;
        logic            w_zero;
        logic            w_hit0;
        logic            w_hit1;
        logic [XLEN-1:0] w_stored;

        assign w_adr    = i_rd_adr[g*AW +: AW];
        assign w_valid  = {{(32-AW){1'b0}}, w_adr} < NREG;
        assign w_zero   = (ZERO_REG != 0) && (w_adr == '0);
        assign w_hit0   = (BYPASS != 0) && i_wr_en[0] && (w_wa0 == w_adr);
        assign w_hit1   = (BYPASS != 0) && i_wr_en[1] && (w_wa1 == w_adr);
        assign w_stored = w_valid ? r_regs[w_adr] : '0;

        assign o_rd_data[g*XLEN +: XLEN] = (!i_rst_n || !w_valid || w_zero) ? '0 :
                                           w_hit1 ? w_wd1 :
                                           w_hit0 ? w_wd0 : w_stored;

        // A bypassed write delivers the value now, so the consumer need not stall.
        assign o_rd_busy[g] = i_rst_n && w_valid && !w_zero && r_busy[w_adr] &&
                              !(w_hit0 || w_hit1);
    end

    assign o_any_busy = |r_busy;

endmodule

// File: tb/tb_otter_regfile_mp.sv
// Randomised and directed bench for otter_regfile_mp against an array-based register model.
module tb_otter_regfile_mp;
    localparam int XLEN  = 32;
    localparam int NREG  = 32;
    localparam int NREAD = 2;
    localparam int AW    = 5;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREAD*AW-1:0]   rd_adr;
    logic [NREAD*XLEN-1:0] rd_data;
    logic [NREAD-1:0]      rd_busy;
    logic [1:0]            wr_en;
    logic [2*AW-1:0]       wr_adr;
    logic [2*XLEN-1:0]     wr_data;
    logic                  sb_set;
    logic [AW-1:0]         sb_adr;
    logic                  any_busy;

    otter_regfile_mp #(
        .XLEN(XLEN), .NREG(NREG), .NREAD(NREAD), .BYPASS(1), .ZERO_REG(1)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rd_adr(rd_adr), .o_rd_data(rd_data),
        .o_rd_busy(rd_busy), .i_wr_en(wr_en), .i_wr_adr(wr_adr), .i_wr_data(wr_data),
        .i_sb_set(sb_set), .i_sb_adr(sb_adr), .o_any_busy(any_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    logic [31:0] m_reg  [NREG];
    logic        m_busy [NREG];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic bit m_wr_hits(input int a);
        return (wr_en[0] && int'(wr_adr[AW-1:0]) == a) || (wr_en[1] && int'(wr_adr[2*AW-1:AW]) == a);
    endfunction

    function automatic logic [31:0] m_rd(input int a);
        if (!rst_n || a == 0) return 32'h0;
        if (wr_en[1] && int'(wr_adr[2*AW-1:AW]) == a) return wr_data[63:32];
        if (wr_en[0] && int'(wr_adr[AW-1:0]) == a) return wr_data[31:0];
        return m_reg[a];
    endfunction

    function automatic logic m_rbusy(input int a);
        if (!rst_n || a == 0 || m_wr_hits(a)) return 1'b0;
        return m_busy[a];
    endfunction

    function automatic logic m_any();
        logic r = 1'b0;
        for (int a = 0; a < NREG; a++) r = r | m_busy[a];
        return r;
    endfunction

    // Model state: later nonblocking assignment wins, giving port-1 and set priority.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int a = 0; a < NREG; a++) begin
                m_reg[a]  <= 32'h0;
                m_busy[a] <= 1'b0;
            end
        end else begin
            if (wr_en[0] && wr_adr[AW-1:0] != 0) m_reg[wr_adr[AW-1:0]] <= wr_data[31:0];
            if (wr_en[1] && wr_adr[2*AW-1:AW] != 0) m_reg[wr_adr[2*AW-1:AW]] <= wr_data[63:32];
            for (int a = 1; a < NREG; a++) begin
                if (m_wr_hits(a)) m_busy[a] <= 1'b0;
                if (sb_set && int'(sb_adr) == a) m_busy[a] <= 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < NREAD; i++) begin
                check($sformatf("model rd_data[%0d]", i), rd_data[i*XLEN +: XLEN],
                      m_rd(int'(rd_adr[i*AW +: AW])));
                check($sformatf("model rd_busy[%0d]", i), 32'(rd_busy[i]),
                      32'(m_rbusy(int'(rd_adr[i*AW +: AW]))));
            end
            check("model any_busy", 32'(any_busy), 32'(m_any()));
        end
    end

    task automatic drive(input logic [1:0] we, input int wa0, input logic [31:0] wd0,
                         input int wa1, input logic [31:0] wd1, input logic sb,
                         input int sa, input int ra0, input int ra1);
        wr_en   = we;
        wr_adr  = {AW'(wa1), AW'(wa0)};
        wr_data = {wd1, wd0};
        sb_set  = sb;
        sb_adr  = AW'(sa);
        rd_adr  = {AW'(ra1), AW'(ra0)};
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        #1 rst_n = 1'b0;
        chk_en = 1'b1;
        repeat (2) next_cycle();
        check("reset rd_data0", rd_data[31:0], 32'h0);
        check("reset any_busy", 32'(any_busy), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        // Write then read back, same-cycle bypass first.
        next_cycle();
        drive(2'b01, 3, 32'h12345678, 0, 0, 1'b0, 0, 3, 0);
        #1 check("T2 bypass x3", rd_data[31:0], 32'h12345678);
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 3, 0);
        #1 check("T2 stored x3", rd_data[31:0], 32'h12345678);

        // Zero register.
        next_cycle();
        drive(2'b01, 0, 32'hFFFFFFFF, 0, 0, 1'b1, 0, 0, 0);
        #1 check("T3 bypass x0", rd_data[31:0], 32'h0);
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        #1 check("T3 stored x0", rd_data[31:0], 32'h0);
        check("T3 busy x0", 32'(rd_busy[0]), 32'h0);
        check("T3 any_busy", 32'(any_busy), 32'h0);

        // Collision: port 1 wins.
        next_cycle();
        drive(2'b11, 7, 32'h1, 7, 32'h2, 1'b0, 0, 0, 7);
        #1 check("T4 bypass x7", rd_data[63:32], 32'h2);
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 7);
        #1 check("T4 stored x7", rd_data[63:32], 32'h2);

        // Scoreboard set then clear through port 1.
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 1'b1, 9, 9, 0);
        #1 check("T5 busy during set", 32'(rd_busy[0]), 32'h0);
        check("T5 any during set", 32'(any_busy), 32'h0);
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 0);
        #1 check("T5 busy after set", 32'(rd_busy[0]), 32'h1);
        check("T5 any after set", 32'(any_busy), 32'h1);
        next_cycle();
        drive(2'b10, 0, 0, 9, 32'hA5A5A5A5, 1'b0, 0, 9, 0);
        #1 check("T5 busy during wr", 32'(rd_busy[0]), 32'h0);
        check("T5 any during wr", 32'(any_busy), 32'h1);
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 9, 0);
        #1 check("T5 busy after wr", 32'(rd_busy[0]), 32'h0);
        check("T5 any after wr", 32'(any_busy), 32'h0);
        check("T5 data x9", rd_data[31:0], 32'hA5A5A5A5);

        // Set and clear of the same register in one cycle.
        next_cycle();
        drive(2'b01, 4, 32'h44, 0, 0, 1'b1, 4, 0, 0);
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 4, 0);
        #1 check("T6 busy x4", 32'(rd_busy[0]), 32'h1);
        check("T6 data x4", rd_data[31:0], 32'h44);
        next_cycle();
        drive(2'b10, 0, 0, 4, 32'h45, 1'b0, 0, 4, 0);

        // Asynchronous reset mid-cycle.
        next_cycle();
        drive(2'b01, 5, 32'hDEADBEEF, 0, 0, 1'b0, 0, 0, 0);
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 1'b1, 12, 5, 0);
        #1 check("T1 before reset", rd_data[31:0], 32'hDEADBEEF);
        next_cycle();
        #2 rst_n = 1'b0;
        #1 check("T1 reset data x5", rd_data[31:0], 32'h0);
        check("T1 reset any_busy", 32'(any_busy), 32'h0);
        @(negedge clk);
        #1 rst_n = 1'b1;

        for (int c = 0; c < 600; c++) begin
            next_cycle();
            drive(2'($urandom), int'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 7)),
                  $urandom, 1'($urandom), int'($urandom_range(0, 7)),
                  int'($urandom_range(0, 7)), int'($urandom_range(0, 31)));
        end
        next_cycle();
        drive(2'b00, 0, 0, 0, 0, 1'b0, 0, 0, 0);
        next_cycle();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
